// File: rtl/logic_unit_seq.sv
// rtl/logic_unit_seq.sv - bitwise logic unit with elementwise and multi-beat reduce modes
module logic_unit_seq #(
    parameter int WIDTH = 8,
    parameter int BEATS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [2:0]       op_q;

    logic acc_open;
    logic out_free;
    logic in_xfer;
    logic out_xfer;
    logic start_burst;
    logic last_beat;
    logic load_out;

    function automatic logic [WIDTH-1:0] f(input logic [2:0] o,
                                           input logic [WIDTH-1:0] p,
                                           input logic [WIDTH-1:0] q);
        case (o)
            3'b000:  return ~p;
            3'b001:  return p & q;
            3'b010:  return p | q;
            3'b011:  return ~(p & q);
            3'b100:  return ~(p | q);
            3'b101:  return p ^ q;
            3'b110:  return ~(p ^ q);
            default: return p;
        endcase
    endfunction

    assign acc_open = (state == ACC) && (cnt < LAST);
    assign out_free = !out_valid || out_ready;
    // A first reduce beat never touches the output register, so it need not wait for it to drain.
    assign in_ready = acc_open || ((state == IDLE) && mode) || out_free;

    assign in_xfer     = in_valid && in_ready;
    assign out_xfer    = out_valid && out_ready;
    assign start_burst = in_xfer && (state == IDLE) && mode;
    assign last_beat   = in_xfer && (state == ACC) && (cnt == LAST);
    assign load_out    = (in_xfer && (state == IDLE) && !mode) || last_beat;
    assign busy        = (state == ACC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_burst) state_nxt = ACC;
            ACC:     if (last_beat)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            acc  <= '0;
            op_q <= '0;
        end else if (start_burst) begin
            acc  <= f(op, a, b);
            cnt  <= CNT_W'(1);
            op_q <= op;
        end else if (in_xfer && (state == ACC)) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                acc <= f(op_q, acc, a);
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y         <= '0;
            out_valid <= 1'b0;
        end else if (load_out) begin
            y         <= (state == ACC) ? f(op_q, acc, a) : f(op, a, b);
            out_valid <= 1'b1;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

endmodule
